uart_program_loader: RTL
========================

Name: uart_program_loader

Overview:
- Sits between the UART receiver FIFO and the instruction-memory write port of the mips core.
- Pops bytes from the UART RX FIFO and packs them MSB-first into 32-bit instruction words.
- Writes each word to sequential instruction-memory addresses.
- Stops on the halt word or when instruction memory is full, then reports completion to the debug control FSM.

Parameters:
- SIZE, 32, instruction word width; fixed at 4 bytes.
- MAX_INSTRUCTION, 64, instruction memory depth in words.
- ADDR_WIDTH, $clog2(MAX_INSTRUCTION), instruction memory address width.
- HALT_WORD, 32'hFFFFFFFF, end-of-program marker.
- TIMEOUT_CYCLES, 1000000, inter-byte timeout; used only with LOADER_TIMEOUT_EN.

Ports:
- i_clk  in  1  system clock (clk_wiz output domain)
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  one-cycle request to begin loading
- i_rx_empty  in  1  UART RX FIFO empty flag
- i_rx_data  in  8  UART RX FIFO head byte; first-word-fall-through, valid while i_rx_empty=0
- o_rd_uart  out  1  FIFO pop strobe
- o_imem_we  out  1  instruction memory write enable
- o_imem_addr  out  ADDR_WIDTH  write address
- o_imem_data  out  SIZE  write data
- o_busy  out  1  high while not IDLE
- o_done  out  1  one-cycle completion pulse
- o_count  out  ADDR_WIDTH+1  words written in the last or current load, halt word included
- o_error  out  1  timeout flag; present only with LOADER_TIMEOUT_EN

Behaviour:
- One clock (i_clk); reset is synchronous and active-high (i_rst), sampled on the rising edge.
- Reset values:
  - state IDLE.
  - o_rd_uart, o_imem_we, o_busy, o_done, o_error = 0.
  - o_imem_addr, o_imem_data, o_count = 0.
  - Internal byte index and word shift register cleared.
- Reset mid-load: the partial word is discarded and no write is issued; memory contents already written are left untouched.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - On i_start=1: clear o_count, byte index and address; go to RECV next cycle.
  - FIFO bytes arriving in IDLE are not popped.
- RECV:
  - o_rd_uart = (state==RECV) & ~i_rx_empty, combinational, so back-to-back pops are allowed.
  - On each pop edge, the byte shifts in: word <= {word[23:0], i_rx_data]}. The first byte lands in bits [31:24].
  - The byte index increments on each pop; the 4th pop moves the FSM to WRITE.
- WRITE (exactly one cycle):
  - o_imem_we=1, o_imem_addr = current address, o_imem_data = assembled word.
  - o_count increments on this edge.
  - No pop occurs in this cycle.
- Exit from WRITE:
  - If word == HALT_WORD, or address == MAX_INSTRUCTION-1, go to DONE.
  - Otherwise increment the address, clear the byte index and return to RECV.
- Write latency: the memory write occurs 1 cycle after the 4th byte is popped.
- DONE: o_done=1 for one cycle, then IDLE. o_count holds its value until the next i_start.
- Boundary rules:
  - i_start while busy is ignored.
  - The halt word is itself written to memory.
  - A full load of 64 words without a halt ends with o_count=64 and a last address of 63; the address never wraps.
  - Bytes after DONE remain in the FIFO.
- o_busy = (state != IDLE), registered alongside the state.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Enabled:
  - A counter runs in RECV and resets on each pop.
  - If it reaches TIMEOUT_CYCLES-1 while the byte index != 0 or o_count != 0, the FSM goes to DONE with o_error=1.
  - o_error is sticky until the next i_start or reset.
  - The partial word is not written.
- Disabled: the o_error port and counter are absent, and RECV waits indefinitely.

Decomposition:
- Shared package mips_pkg:
  - loader state enum (IDLE/RECV/WRITE/DONE).
  - HALT_WORD constant.
  - BYTES_PER_WORD=4.
- Sub-module byte_packer: shift register plus byte index, with inputs (clk, rst, clr, push, byte) and outputs (word, full). The top-level FSM stays in uart_program_loader.

Test Plan:
- Start, then FIFO supplies 12 34 56 78 AA BB CC DD FF FF FF FF with no gaps -> writes:
  - addr0=32'h12345678
  - addr1=32'hAABBCCDD
  - addr2=32'hFFFFFFFF
  - o_done pulses; o_count=3.
- Bytes delivered with random 0-20 cycle gaps -> identical writes. o_rd_uart is never high while i_rx_empty=1, and exactly one pop occurs per byte.
- 256 bytes with no halt word -> 64 writes at addr 0..63, DONE after addr 63, o_count=64, remaining FIFO bytes untouched.
- i_rst asserted after 2 bytes of word 1 -> outputs return to reset values next edge, no write to addr1. A new start plus 4 bytes writes to addr0.
- i_start pulsed mid-load -> ignored; o_count is not cleared and the address sequence continues.
- LOADER_TIMEOUT_EN with TIMEOUT_CYCLES=50: send 2 bytes then stall -> o_error=1 and o_done pulses 50 cycles after the last pop, with no partial write.

Source files
------------

// File: rtl/uart_program_loader_pkg.sv
// Shared loader definitions: FSM state encoding, word geometry and the end-of-program marker.
package mips_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam logic [31:0] HALT_WORD      = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } loader_state_e;

endpackage

// File: rtl/uart_program_loader_if.sv
// Loader bus bundle: UART RX FIFO read side plus instruction-memory write port.
interface uart_program_loader_if #(
    parameter int unsigned SIZE       = 32,
    parameter int unsigned ADDR_WIDTH = 6
);
    logic                  i_rx_empty;
    logic [7:0]            i_rx_data;
    logic                  o_rd_uart;
    logic                  o_imem_we;
    logic [ADDR_WIDTH-1:0] o_imem_addr;
    logic [SIZE-1:0]       o_imem_data;

    modport master (
        input  i_rx_empty,
        input  i_rx_data,
        output o_rd_uart,
        output o_imem_we,
        output o_imem_addr,
        output o_imem_data
    );

    modport slave (
        output i_rx_empty,
        output i_rx_data,
        input  o_rd_uart,
        input  o_imem_we,
        input  o_imem_addr,
        input  o_imem_data
    );

endinterface

// File: rtl/uart_program_loader_byte_packer.sv
// byte_packer: MSB-first byte shift register with a byte index; first byte ends up in the top byte.
module byte_packer
    import mips_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        push,
    input  logic [7:0]                  i_byte,
    output logic [8*BYTES_PER_WORD-1:0] o_word,
    output logic                        o_full
);

    localparam int unsigned IDX_W  = $clog2(BYTES_PER_WORD);
    localparam int unsigned WORD_W = 8 * BYTES_PER_WORD;

    logic [WORD_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (clr) begin
            word_d = '0;
            idx_d  = '0;
        end else if (push) begin
            word_d = {word_q[WORD_W-9:0], i_byte};
            idx_d  = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign o_word = word_q;
    // Flags the push that completes the word, so the FSM can leave RECV on that same edge.
    assign o_full = push && !clr && (idx_q == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/uart_program_loader.sv
// UART program loader: packs RX FIFO bytes into instruction words and writes them to IMEM.
// Optional inter-byte timeout with sticky o_error when LOADER_TIMEOUT_EN is defined.
module uart_program_loader
    import mips_pkg::*;
#(
    parameter int unsigned SIZE            = 32,
    parameter int unsigned MAX_INSTRUCTION = 64,
    parameter int unsigned ADDR_WIDTH      = $clog2(MAX_INSTRUCTION)
`ifdef LOADER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    uart_program_loader_if.master bus,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH:0]   o_count
`ifdef LOADER_TIMEOUT_EN
    ,
    output logic                  o_error
`endif
);

    loader_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  busy_q, busy_d;
    logic                  clr;
    logic                  push;
    logic                  full;
    logic [SIZE-1:0]       word;

`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             pending_q, pending_d;
    logic             error_q, error_d;
`endif

    byte_packer u_packer (
        .clk    (i_clk),
        .rst    (i_rst),
        .clr    (clr),
        .push   (push),
        .i_byte (bus.i_rx_data),
        .o_word (word),
        .o_full (full)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        clr     = 1'b0;
        push    = (state_q == RECV) && !bus.i_rx_empty;
`ifdef LOADER_TIMEOUT_EN
        error_d   = error_q;
        pending_d = pending_q;
        timer_d   = '0;
`endif
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    count_d = '0;
                    addr_d  = '0;
                    clr     = 1'b1;
                    state_d = RECV;
`ifdef LOADER_TIMEOUT_EN
                    error_d = 1'b0;
`endif
                end
            end
            RECV: begin
                if (full) state_d = WRITE;
            end
            WRITE: begin
                count_d = count_q + (ADDR_WIDTH + 1)'(1);
                if (word == HALT_WORD || addr_q == ADDR_WIDTH'(MAX_INSTRUCTION - 1)) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    clr     = 1'b1;
                    state_d = RECV;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef LOADER_TIMEOUT_EN
        if (clr) pending_d = 1'b0;
        else if (push) pending_d = 1'b1;
        // Timer saturates while nothing has arrived yet, so an idle RECV never aborts.
        if (state_q == RECV && !push) begin
            if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                timer_d = timer_q;
                if (pending_q || count_q != '0) begin
                    state_d = DONE;
                    error_d = 1'b1;
                end
            end else begin
                timer_d = timer_q + TMR_W'(1);
            end
        end
`endif
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

`ifdef LOADER_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            timer_q   <= '0;
            pending_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            pending_q <= pending_d;
            error_q   <= error_d;
        end
    end

    assign o_error = error_q;
`endif

    assign bus.o_rd_uart   = push;
    assign bus.o_imem_we   = (state_q == WRITE);
    assign bus.o_imem_addr = addr_q;
    assign bus.o_imem_data = word;
    assign o_busy          = busy_q;
    assign o_done          = (state_q == DONE);
    assign o_count         = count_q;

endmodule
